// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU. The result appears WIDTH cycles after start is accepted.
// start is ignored while busy is high; outputs hold their value until the next completion.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] prem, prem_nxt;
   logic [WIDTH-1:0] qreg, qreg_nxt;
   logic [WIDTH-1:0] dvs_mag, dvs_mag_nxt;
   logic [WIDTH-1:0] dvd_raw, dvd_raw_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             neg_q, neg_q_nxt;
   logic             neg_r, neg_r_nxt;
   logic             zero_dvs, zero_dvs_nxt;
   logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
   logic             done_nxt, dbz_nxt;

   logic [WIDTH:0]   shifted, diff;
   logic [WIDTH-1:0] step_rem, step_q;

   // The partial remainder stays below the divisor, so diff[WIDTH] is a valid borrow flag.
   assign shifted  = {prem, qreg[WIDTH-1]};
   assign diff     = shifted - {1'b0, dvs_mag};
   assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   assign step_q   = {qreg[WIDTH-2:0], ~diff[WIDTH]};

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         prem        <= '0;
         qreg        <= '0;
         dvs_mag     <= '0;
         dvd_raw     <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_dvs    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         prem        <= prem_nxt;
         qreg        <= qreg_nxt;
         dvs_mag     <= dvs_mag_nxt;
         dvd_raw     <= dvd_raw_nxt;
         cnt         <= cnt_nxt;
         neg_q       <= neg_q_nxt;
         neg_r       <= neg_r_nxt;
         zero_dvs    <= zero_dvs_nxt;
         quotient    <= quotient_nxt;
         remainder   <= remainder_nxt;
         done        <= done_nxt;
         div_by_zero <= dbz_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      prem_nxt      = prem;
      qreg_nxt      = qreg;
      dvs_mag_nxt   = dvs_mag;
      dvd_raw_nxt   = dvd_raw;
      cnt_nxt       = cnt;
      neg_q_nxt     = neg_q;
      neg_r_nxt     = neg_r;
      zero_dvs_nxt  = zero_dvs;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      done_nxt      = 1'b0;
      dbz_nxt       = div_by_zero;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = RUN;
               prem_nxt     = '0;
               qreg_nxt     = (sign && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
               dvs_mag_nxt  = (sign && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
               dvd_raw_nxt  = dividend;
               neg_q_nxt    = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r_nxt    = sign & dividend[WIDTH-1];
               zero_dvs_nxt = (divisor == '0);
               cnt_nxt      = CW'(WIDTH);
            end
         end
         RUN: begin
            prem_nxt = step_rem;
            qreg_nxt = step_q;
            cnt_nxt  = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               dbz_nxt   = zero_dvs;
               // Negating a zero remainder yields zero, so no extra guard is needed.
               if (zero_dvs) begin
                  quotient_nxt  = '1;
                  remainder_nxt = dvd_raw;
               end else begin
                  quotient_nxt  = neg_q ? (~step_q + 1'b1) : step_q;
                  remainder_nxt = neg_r ? (~step_rem + 1'b1) : step_rem;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed rounding, overflow, divide by zero,
// start handshaking and asynchronous reset abort.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sign;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   div_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .sign        (sign),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      sign     = s;
      dividend = a;
      divisor  = b;
   endtask

   // Accept at E0, expect busy through E31 with no done, completion at E32.
   task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez);
      int bad;
      drive(s, a, b);
      tick();
      start = 1'b0;
      chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
      bad = 0;
      for (int i = 1; i < 32; i++) begin
         tick();
         if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      chk({tag, "_busy_window"}, bad, 32'd0);
      tick();
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_q_hold"}, quotient, eq);
   endtask

   initial begin
      int bad;
      int seen;
      rst      = 1'b0;
      start    = 1'b0;
      sign     = 1'b0;
      dividend = '0;
      divisor  = '0;
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_div("sneg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_div("s7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_div("uovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      run_div("sdz", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
      run_div("s9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      run_div("sneg6_3", 1'b1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 32'd0, 1'b0);

      // start during busy is ignored
      drive(1'b0, 32'd100, 32'd7);
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      drive(1'b0, 32'd50, 32'd5);
      tick();
      start    = 1'b0;
      dividend = 32'd1;
      divisor  = 32'd1;
      for (int i = 11; i < 32; i++) tick();
      tick();
      chk("ign_done", {31'd0, done}, 32'd1);
      chk("ign_q", quotient, 32'd14);
      chk("ign_r", remainder, 32'd2);

      // start in the done cycle is accepted
      drive(1'b0, 32'd50, 32'd5);
      tick();
      start = 1'b0;
      chk("b2b_done_drop", {31'd0, done}, 32'd0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      bad = 0;
      for (int i = 1; i < 32; i++) begin
         tick();
         if (quotient !== 32'd14 || done !== 1'b0) bad++;
      end
      chk("b2b_hold_window", bad, 32'd0);
      tick();
      chk("b2b_done2", {31'd0, done}, 32'd1);
      chk("b2b_q", quotient, 32'd10);
      chk("b2b_r", remainder, 32'd0);
      tick();

      // asynchronous reset aborts an operation
      drive(1'b0, 32'd1000, 32'd3);
      tick();
      start = 1'b0;
      for (int i = 1; i < 12; i++) tick();
      chk("abort_q_before", quotient, 32'd10);
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_q", quotient, 32'd0);
      chk("abort_r", remainder, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      tick();
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("abort_no_done", seen, 32'd0);
      run_div("post_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
